// File: rtl/vga_timing_pkg.sv
// Shared timing constants and widths for the 640x480@60 Hz VGA raster generator.
package vga_timing_pkg;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;

   // Derived totals and the first visible count on each axis (sync comes first in a line/frame).
   localparam int VGA_H_TOTAL     = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
   localparam int VGA_V_TOTAL     = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
   localparam int VGA_H_VIS_START = VGA_H_SYNC + VGA_H_BACK;
   localparam int VGA_V_VIS_START = VGA_V_SYNC + VGA_V_BACK;

   localparam int COORD_W = 10;
   localparam int ADDR_W  = 19;

   function automatic int axis_total(input int vis, input int front, input int sync, input int back);
      return vis + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus combinational sync/visible decode of its current count.
module vga_axis_counter #(
   parameter int TOTAL     = 800,
   parameter int SYNC      = 96,
   parameter int VIS_START = 144,
   parameter int VIS_END   = 784,
   parameter int CW        = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          advance,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          sync_n,
   output logic          visible
);

   localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
   localparam logic [CW-1:0] SYNC_C = CW'(SYNC);
   localparam logic [CW-1:0] VS_C   = CW'(VIS_START);
   localparam logic [CW-1:0] VE_C   = CW'(VIS_END);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (advance) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   assign wrap    = advance && (count == LAST);
   assign sync_n  = (count >= SYNC_C);
   assign visible = (count >= VS_C) && (count < VE_C);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: registered sync, blanking, visible coordinates and a linear frame-buffer address.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FRONT   = VGA_H_FRONT,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BACK    = VGA_H_BACK,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FRONT   = VGA_V_FRONT,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BACK    = VGA_V_BACK
) (
   input  logic               iVGA_CLK,
   input  logic               iRST_n,
   output logic               oHS,
   output logic               oVS,
   output logic               oBLANK_n,
   output logic [COORD_W-1:0] oX,
   output logic [COORD_W-1:0] oY,
   output logic [ADDR_W-1:0]  oADDR,
   output logic               oFRAME_START
);

   localparam int H_TOT = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOT = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
   localparam int H_VS0 = H_SYNC + H_BACK;
   localparam int V_VS0 = V_SYNC + V_BACK;

   localparam logic [COORD_W-1:0] H_OFF = COORD_W'(H_VS0);
   localparam logic [COORD_W-1:0] V_OFF = COORD_W'(V_VS0);

   logic [COORD_W-1:0] h_cnt;
   logic [COORD_W-1:0] v_cnt;
   logic               h_wrap;
   logic               v_wrap;
   logic               h_sync_n;
   logic               v_sync_n;
   logic               h_vis;
   logic               v_vis;
   logic               vis;
   logic [ADDR_W-1:0]  addr_nxt;

   vga_axis_counter #(
      .TOTAL(H_TOT), .SYNC(H_SYNC), .VIS_START(H_VS0), .VIS_END(H_VS0 + H_VISIBLE), .CW(COORD_W)
   ) u_h_axis (
      .clk(iVGA_CLK), .rst_n(iRST_n), .advance(1'b1),
      .count(h_cnt), .wrap(h_wrap), .sync_n(h_sync_n), .visible(h_vis)
   );

   vga_axis_counter #(
      .TOTAL(V_TOT), .SYNC(V_SYNC), .VIS_START(V_VS0), .VIS_END(V_VS0 + V_VISIBLE), .CW(COORD_W)
   ) u_v_axis (
      .clk(iVGA_CLK), .rst_n(iRST_n), .advance(h_wrap),
      .count(v_cnt), .wrap(v_wrap), .sync_n(v_sync_n), .visible(v_vis)
   );

   assign vis = h_vis & v_vis;

   // Outputs describe the position the counters held before this edge (one clock latency).
   always_ff @(posedge iVGA_CLK) begin
      if (!iRST_n) begin
         oHS          <= 1'b1;
         oVS          <= 1'b1;
         oBLANK_n     <= 1'b0;
         oX           <= '0;
         oY           <= '0;
         oADDR        <= '0;
         oFRAME_START <= 1'b0;
      end else begin
         oHS          <= h_sync_n;
         oVS          <= v_sync_n;
         oBLANK_n     <= vis;
         oX           <= vis ? h_cnt - H_OFF : '0;
         oY           <= vis ? v_cnt - V_OFF : '0;
         oADDR        <= vis ? addr_nxt : '0;
         oFRAME_START <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

   // Address of the next visible pixel; walks row-major and is cleared on the last frame position.
   always_ff @(posedge iVGA_CLK) begin
      if (!iRST_n) begin
         addr_nxt <= '0;
      end else if (v_wrap) begin
         addr_nxt <= '0;
      end else if (vis) begin
         addr_nxt <= addr_nxt + 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a scaled-down raster and the full 640x480 raster checked against an arithmetic model.
module tb_vga_timing_gen;

   localparam int SH_V = 20, SH_F = 3, SH_S = 5, SH_B = 4;
   localparam int SV_V = 6,  SV_F = 2, SV_S = 2, SV_B = 3;
   localparam int FH_V = 640, FH_F = 16, FH_S = 96, FH_B = 48;
   localparam int FV_V = 480, FV_F = 10, FV_S = 2, FV_B = 33;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic s_hs, s_vs, s_blank, s_fs;
   logic [9:0] s_x, s_y;
   logic [18:0] s_addr;
   logic f_hs, f_vs, f_blank, f_fs;
   logic [9:0] f_x, f_y;
   logic [18:0] f_addr;
   logic [42:0] s_pack, f_pack;

   assign s_pack = {s_hs, s_vs, s_blank, s_fs, s_x, s_y, s_addr};
   assign f_pack = {f_hs, f_vs, f_blank, f_fs, f_x, f_y, f_addr};

   vga_timing_gen #(
      .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
      .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B)
   ) dut_small (
      .iVGA_CLK(clk), .iRST_n(rst_n), .oHS(s_hs), .oVS(s_vs), .oBLANK_n(s_blank),
      .oX(s_x), .oY(s_y), .oADDR(s_addr), .oFRAME_START(s_fs)
   );

   vga_timing_gen dut_full (
      .iVGA_CLK(clk), .iRST_n(rst_n), .oHS(f_hs), .oVS(f_vs), .oBLANK_n(f_blank),
      .oX(f_x), .oY(f_y), .oADDR(f_addr), .oFRAME_START(f_fs)
   );

   int tests = 0;
   int fails = 0;
   bit rs = 1'b1;
   longint pos = 0;

   // Expected outputs for raster position index pos (clocks since the release edge), or reset values.
   function automatic logic [42:0] model(input int hv, input int hf, input int hsw, input int hb,
                                         input int vv, input int vf, input int vsw, input int vb,
                                         input bit in_rst, input longint p);
      int ht, vt, h, v, x, y, a;
      logic hs_e, vs_e, vis_e, fs_e;
      logic [9:0] xl, yl;
      logic [18:0] al;
      if (in_rst) return {1'b1, 1'b1, 1'b0, 1'b0, 39'd0};
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      h = int'(p % ht);
      v = int'((p / ht) % vt);
      hs_e = !(h < hsw);
      vs_e = !(v < vsw);
      vis_e = (h >= hsw + hb) && (h < hsw + hb + hv) && (v >= vsw + vb) && (v < vsw + vb + vv);
      fs_e = (h == 0) && (v == 0);
      x = vis_e ? h - hsw - hb : 0;
      y = vis_e ? v - vsw - vb : 0;
      a = vis_e ? y * hv + x : 0;
      xl = x[9:0];
      yl = y[9:0];
      al = a[18:0];
      return {hs_e, vs_e, vis_e, fs_e, xl, yl, al};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: drive reset, advance the model on the edge, compare both instances on the falling edge.
   task automatic cycle(input bit r);
      rst_n = r;
      @(posedge clk);
      if (!r) begin
         rs = 1'b1;
         pos = 0;
      end else if (rs) begin
         rs = 1'b0;
         pos = 0;
      end else begin
         pos++;
      end
      @(negedge clk);
      check("small_model", {21'd0, s_pack},
            {21'd0, model(SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, rs, pos)});
      check("full_model", {21'd0, f_pack},
            {21'd0, model(FH_V, FH_F, FH_S, FH_B, FV_V, FV_F, FV_S, FV_B, rs, pos)});
   endtask

   typedef struct {
      bit         rst;
      logic       hs, vs, blank, fs;
      logic [9:0] x, y;
      logic [18:0] addr;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int cnt, per, found, vs_low, blank_cnt, rises, len, tcount, tfall;
      int lastx, lasty, lasta;
      bit prev, prevb;

      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 19'd0};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 19'd0};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 19'd0};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 19'd0};

      for (int i = 0; i < 8; i++) begin
         cycle(vecs[i].rst);
         check($sformatf("vec%0d", i), {21'd0, s_pack},
               {21'd0, vecs[i].hs, vecs[i].vs, vecs[i].blank, vecs[i].fs, vecs[i].x, vecs[i].y, vecs[i].addr});
      end

      // Horizontal sync width and line period on the small raster.
      found = 0;
      for (int k = 0; k < 200; k++) begin
         prev = s_hs;
         cycle(1'b1);
         if (prev && !s_hs) begin found = 1; break; end
      end
      check("hs_fall_found", found, 1);
      cnt = 1;
      for (int k = 0; k < 1000; k++) begin
         cycle(1'b1);
         if (!s_hs) cnt++; else break;
      end
      check("hs_low_width", cnt, SH_S);
      per = cnt;
      found = 0;
      for (int k = 0; k < 1000; k++) begin
         prev = s_hs;
         cycle(1'b1);
         per++;
         if (prev && !s_hs) begin found = 1; break; end
      end
      check("hs_period", found ? per : -1, 32);

      // One full small frame from frame-start to frame-start.
      found = 0;
      for (int k = 0; k < 1000; k++) begin
         cycle(1'b1);
         if (s_fs) begin found = 1; break; end
      end
      check("fs_found", found, 1);
      per = 0; vs_low = 0; blank_cnt = 0; rises = 0; prevb = 1'b0;
      lastx = -1; lasty = -1; lasta = -1;
      for (int k = 0; k < 2000; k++) begin
         if (!s_vs) vs_low++;
         if (s_blank) begin
            blank_cnt++;
            if (!prevb) rises++;
            lastx = int'(s_x); lasty = int'(s_y); lasta = int'(s_addr);
            check("addr_linear", s_addr, int'(s_y) * SH_V + int'(s_x));
         end
         prevb = s_blank;
         cycle(1'b1);
         per++;
         if (s_fs) break;
      end
      check("frame_period", per, 416);
      check("vs_low_clocks", vs_low, 64);
      check("blank_pulses", rises, 6);
      check("blank_clocks", blank_cnt, 120);
      check("last_pixel", {lastx[15:0], lasty[15:0], lasta[31:0]}, {16'd19, 16'd5, 32'd119});

      // Full raster: first visible pixel, blank offset from HS, first line and start of the second.
      found = 0; tcount = 0; tfall = -100000; prev = f_hs;
      for (int k = 0; k < 40000; k++) begin
         prev = f_hs;
         cycle(1'b1);
         tcount++;
         if (prev && !f_hs) tfall = tcount;
         if (f_blank) begin found = 1; break; end
      end
      check("full_blank_found", found, 1);
      check("full_hs_to_blank", tcount - tfall, 144);
      check("full_first_pixel", {f_x, f_y, f_addr}, {10'd0, 10'd0, 19'd0});
      len = 1; lastx = int'(f_x); lasty = int'(f_y); lasta = int'(f_addr);
      for (int k = 0; k < 2000; k++) begin
         cycle(1'b1);
         if (!f_blank) break;
         len++;
         lastx = int'(f_x); lasty = int'(f_y); lasta = int'(f_addr);
      end
      check("full_line_len", len, 640);
      check("full_line_end", {lastx[15:0], lasty[15:0], lasta[31:0]}, {16'd639, 16'd0, 32'd639});
      found = 0;
      for (int k = 0; k < 400; k++) begin
         cycle(1'b1);
         if (f_blank) begin found = 1; break; end
      end
      check("full_line2_found", found, 1);
      check("full_line2_start", {f_x, f_y, f_addr}, {10'd0, 10'd1, 19'd640});

      // Random reset pulses; the model compares every clock.
      for (int k = 0; k < 3000; k++) cycle($urandom_range(0, 149) != 0);

      // Mid-frame reset during visible line 3 of the small raster.
      for (int k = 0; k < 5; k++) cycle(1'b1);
      found = 0;
      for (int k = 0; k < 1000; k++) begin
         cycle(1'b1);
         if (s_blank && s_y == 10'd3) begin found = 1; break; end
      end
      check("mid_line_found", found, 1);
      cycle(1'b0);
      check("mid_reset_first_edge", {21'd0, s_pack}, {21'd0, 1'b1, 1'b1, 1'b0, 1'b0, 39'd0});
      cycle(1'b0);
      cycle(1'b0);
      cycle(1'b1);
      check("mid_release", {s_hs, s_vs, s_blank, s_fs}, 4'b0001);
      cycle(1'b1);
      check("mid_fs_pulse", s_fs, 1'b0);
      per = 1; found = 0;
      for (int k = 0; k < 1000; k++) begin
         cycle(1'b1);
         per++;
         if (s_fs) begin found = 1; break; end
      end
      check("mid_frame_period", found ? per : -1, 416);
      for (int k = 0; k < 450; k++) cycle(1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA raster timing for a 640x480@60 Hz display (25.175 MHz pixel clock) from one pixel clock. Outputs active-low HS/VS, an active-high display-enable (blank_n), visible-pixel coordinates and a linear frame-buffer address. It sits between the pixel clock and the frame-buffer/palette lookup path of the display controller.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
iVGA_CLK  in  1  pixel clock; all logic on its rising edge
iRST_n  in  1  reset, synchronous, active-low
oHS  out  1  horizontal sync, active-low
oVS  out  1  vertical sync, active-low
oBLANK_n  out  1  high while the presented position is visible
oX  out  10  visible column 0..H_VISIBLE-1; 0 outside the visible area
oY  out  10  visible row 0..V_VISIBLE-1; 0 outside the visible area
oADDR  out  19  oY*H_VISIBLE+oX when visible; 0 otherwise
oFRAME_START  out  1  one-clock pulse when position (0,0) is presented

Behaviour:
- H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525).
- Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1).
  - h increments every clock and wraps to 0 after H_TOTAL-1.
  - v increments when h wraps, and wraps to 0 after V_TOTAL-1.
- Line order starts with sync: sync, back porch, visible, front porch. Frames follow the same order.
- Decode for position (h,v):
  - HS active (0) when h < H_SYNC.
  - VS active (0) when v < V_SYNC.
  - Visible when H_SYNC+H_BACK <= h < H_SYNC+H_BACK+H_VISIBLE (144..783) and V_SYNC+V_BACK <= v < V_SYNC+V_BACK+V_VISIBLE (35..514).
- All outputs are registered. The outputs after a clock edge describe the position the counters held before that edge, so latency is 1 clock.
- oX and oY are h-144 and v-35 inside the visible area, and 0 elsewhere.
- oADDR is maintained incrementally, with no multiplier:
  - increments by 1 per visible pixel;
  - returns to 0 at frame position (0,0);
  - reads 0 while not visible;
  - must still equal oY*640+oX at every visible pixel.
- While iRST_n=0 at a clock edge: h=v=0, oHS=1, oVS=1, oBLANK_n=0, oX=oY=0, oADDR=0, oFRAME_START=0.
- First edge with iRST_n=1:
  - presents position (0,0): oHS=0, oVS=0, oFRAME_START=1;
  - advances the counters to (1,0).
- Reset asserted mid-frame aborts the frame immediately; no partial-line completion.
- The final position (799,524) wraps to (0,0) with no gap cycle.
- Derived widths: h and v are 10 bits. Sums are computed at 11 bits or more to avoid overflow.

Decomposition:
- Shared package vga_timing_pkg:
  - the eight timing constants;
  - derived H_TOTAL, V_TOTAL, H_VIS_START=144, V_VIS_START=35;
  - width constants (coordinate 10 bits, address 19 bits).
- One natural sub-module: vga_axis_counter. It is parameterized by total and sync/visible bounds, with inputs clk, rst_n and advance. Its outputs are count, wrap, sync_n and visible. It is instantiated once for horizontal (advance=1) and once for vertical (advance=horizontal wrap).
- Top level registers the outputs and owns the address counter.

Test Plan:
- Reset: hold iRST_n=0 for 5 clocks -> oHS=1, oVS=1, oBLANK_n=0, oX=oY=oADDR=0, oFRAME_START=0. Release -> next edge oHS=0, oVS=0, oFRAME_START=1, then oFRAME_START=0.
- Horizontal timing: count clocks over one line -> oHS low for exactly 96 clocks, period 800. oBLANK_n first rises 144 clocks after the HS falling edge on line 35.
- Vertical timing: over a frame -> oVS low for 2 lines (1600 clocks), frame period 420000 clocks. Exactly 480 lines contain oBLANK_n pulses, each 640 clocks long.
- Coordinates/address: on the first visible pixel -> oX=0, oY=0, oADDR=0. Last pixel of the first visible line -> oX=639, oADDR=639. First pixel of the next line -> oY=1, oADDR=640. Last frame pixel -> oX=639, oY=479, oADDR=307199. Scoreboard checks oADDR==oY*640+oX whenever oBLANK_n=1.
- Wrap: run 2 full frames -> oFRAME_START pulses exactly 420000 clocks apart, and oADDR returns to 0 at the second frame's first visible pixel.
- Mid-frame reset: assert iRST_n=0 during visible line 200 for 3 clocks -> reset values appear on the first reset edge. After release, the timing restarts from position (0,0) exactly as after power-up.
